ens_vote_argmax: RTL

- Downstream consumer of the final-layer neuron LUTs of every ensemble member (ens0..ensK).
- Collects one per-class score vector per member and sums the scores per class.
- Then scans the sums sequentially and emits the winning MNIST class.
- Sits between the registered final-layer outputs and the top-level result interface, with valid/ready on both sides.

---
 rtl/ens_vote_argmax_pkg.sv | 18 +
 rtl/ens_vote_argmax_if.sv | 31 +++
 rtl/ens_score_acc.sv | 43 ++++
 rtl/ens_vote_argmax.sv | 97 +++++++++
 4 files changed

// File: rtl/ens_vote_argmax_pkg.sv
// Shared types and sizing helpers for the ensemble vote / argmax block.
// Used by the RTL and by the bench so both agree on widths.
package ens_vote_argmax_pkg;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int DFLT_NUM_CLASSES = 10;

    // Smallest width holding the largest possible per-class sum over all members.
    function automatic int calc_sum_w(input int num_ens, input int score_w);
        return $clog2(num_ens * ((1 << score_w) - 1) + 1);
    endfunction

endpackage

// File: rtl/ens_vote_argmax_if.sv
// Score-vector input and class-result output handshakes of ens_vote_argmax.
// master drives the scores and consumes the result; slave is the voting block.
interface ens_vote_argmax_if
    import ens_vote_argmax_pkg::*;
#(
    parameter int NUM_ENS     = 4,
    parameter int NUM_CLASSES = DFLT_NUM_CLASSES,
    parameter int SCORE_W     = 2
);
    localparam int SUM_W = calc_sum_w(NUM_ENS, SCORE_W);
    localparam int IDX_W = $clog2(NUM_CLASSES);

    logic                           in_valid;
    logic                           in_ready;
    logic [NUM_CLASSES*SCORE_W-1:0] in_scores;
    logic                           out_valid;
    logic                           out_ready;
    logic [IDX_W-1:0]               out_class;
    logic [SUM_W-1:0]               out_score;

    modport master (
        output in_valid, in_scores, out_ready,
        input  in_ready, out_valid, out_class, out_score
    );

    modport slave (
        input  in_valid, in_scores, out_ready,
        output in_ready, out_valid, out_class, out_score
    );

endinterface

// File: rtl/ens_score_acc.sv
// Per-class accumulator bank: load or add one score vector per cycle, clear, indexed read.
// Latency: write visible the cycle after; read is combinational. No backpressure of its own.
// Accepts whatever load/add/clr the controller asserts.
module ens_score_acc #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 2,
    parameter int SUM_W       = 4,
    parameter int IDX_W       = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           load,
    input  logic                           add,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
    input  logic [IDX_W-1:0]               rd_idx,
    output logic [SUM_W-1:0]               rd_dat
);

    logic [SUM_W-1:0] acc [NUM_CLASSES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
        end else if (clr) begin
            for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
        end else if (load) begin
            for (int c = 0; c < NUM_CLASSES; c++)
                acc[c] <= SUM_W'(scores[c*SCORE_W +: SCORE_W]);
        end else if (add) begin
            for (int c = 0; c < NUM_CLASSES; c++)
                acc[c] <= acc[c] + SUM_W'(scores[c*SCORE_W +: SCORE_W]);
        end
    end

    // Decoded mux so indices past NUM_CLASSES-1 read as zero.
    always_comb begin
        rd_dat = '0;
        for (int c = 0; c < NUM_CLASSES; c++)
            if (rd_idx == IDX_W'(c)) rd_dat = acc[c];
    end

endmodule

// File: rtl/ens_vote_argmax.sv
// Sums per-class scores of NUM_ENS ensemble members, then scans for the highest sum (lowest index on ties).
// Latency: NUM_CLASSES cycles from the last member beat to out_valid. in_ready is low outside ACC;
// the result is held in OUT until out_ready.
module ens_vote_argmax
    import ens_vote_argmax_pkg::*;
#(
    parameter int NUM_ENS     = 4,
    parameter int NUM_CLASSES = DFLT_NUM_CLASSES,
    parameter int SCORE_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    ens_vote_argmax_if.slave  bus
);

    localparam int SUM_W = calc_sum_w(NUM_ENS, SCORE_W);
    localparam int IDX_W = $clog2(NUM_CLASSES);
    localparam int CNT_W = (NUM_ENS > 1) ? $clog2(NUM_ENS) : 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] best_idx;
    logic [SUM_W-1:0] best;
    logic [SUM_W-1:0] rd_dat;
    logic             beat_acc, last_beat, scan_last, out_hs;

    assign beat_acc  = (state == ACC) && bus.in_valid;
    assign last_beat = beat_acc && (cnt == CNT_W'(NUM_ENS - 1));
    assign scan_last = (state == SCAN) && (scan_idx == IDX_W'(NUM_CLASSES - 1));
    assign out_hs    = (state == OUT) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ACC: begin
                bus.in_ready = 1'b1;
                if (last_beat) state_nxt = SCAN;
            end
            SCAN: begin
                if (scan_last) state_nxt = OUT;
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = ACC;
            end
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            scan_idx <= '0;
            best     <= '0;
            best_idx <= '0;
        end else begin
            if (beat_acc) cnt <= last_beat ? '0 : cnt + 1'b1;
            if (out_hs)   cnt <= '0;
            if (state == SCAN) begin
                scan_idx <= scan_last ? '0 : scan_idx + 1'b1;
                // Strict compare keeps the earliest class on equal sums.
                if (scan_idx == '0 || rd_dat > best) begin
                    best     <= rd_dat;
                    best_idx <= scan_idx;
                end
            end
        end
    end

    assign bus.out_class = best_idx;
    assign bus.out_score = best;

    ens_score_acc #(
        .NUM_CLASSES (NUM_CLASSES),
        .SCORE_W     (SCORE_W),
        .SUM_W       (SUM_W),
        .IDX_W       (IDX_W)
    ) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (out_hs),
        .load   (beat_acc && (cnt == '0)),
        .add    (beat_acc && (cnt != '0)),
        .scores (bus.in_scores),
        .rd_idx (scan_idx),
        .rd_dat (rd_dat)
    );

endmodule
